mux_scan: RTL and testbench
===========================

MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 The module SHALL have parameter DW, default 2, meaning per-channel data width in bits (DW>=1).
REQ-002 The module SHALL have parameter NCH, default 4, meaning number of input channels (NCH>=2, not necessarily a power of 2).
REQ-003 The module SHALL have parameter DWELL, default 8, meaning cycles spent on each channel in scan mode (DWELL>=1).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-007 sel  input  SW=$clog2(NCH)  channel index used in manual mode and as the scan start point.
REQ-008 din  input  NCH*DW  packed channels; channel k occupies bits [k*DW +: DW].
REQ-009 hold  input  1  freezes all state while high.
REQ-010 f  output  DW  registered selected data.
REQ-011 f_ch  output  SW  index of the channel currently driven on f.
REQ-012 f_vld  output  1  f holds a valid capture.
REQ-013 wrap  output  1  one-cycle pulse when the scan pointer wraps from NCH-1 to 0.

Function
REQ-014 Manual mode SHALL register din[sel] into f and sel into f_ch with 1-cycle latency; f_vld SHALL become 1 the cycle after a valid sel is sampled.
REQ-015 sel>=NCH (non-power-of-2 NCH) SHALL leave f and f_ch unchanged and drive f_vld=0 the next cycle.
REQ-016 Scan mode SHALL keep pointer p and dwell counter cnt (0..DWELL-1); each unheld cycle SHALL capture f<=din[p], f_ch<=p, f_vld<=1.
REQ-017 When cnt==DWELL-1, cnt SHALL clear and p SHALL advance to p+1, or to 0 if p==NCH-1; otherwise cnt SHALL increment.
REQ-018 wrap SHALL be 1 for exactly the one cycle in which f_ch first shows 0 after NCH-1, and 0 otherwise.
REQ-019 On a sampled 0->1 mode transition, p SHALL load sel (0 if sel>=NCH) and cnt SHALL clear; f_ch shows the start channel on the next cycle.
REQ-020 On a sampled 1->0 transition, manual behaviour SHALL apply from that same edge; p and cnt retain their values but are unused.
REQ-021 hold=1 SHALL freeze f, f_ch, f_vld, p, cnt and the sampled mode; wrap SHALL be 0 during hold; resuming SHALL complete the remaining dwell.
REQ-022 hold and a mode change in the same cycle: hold SHALL win; the change takes effect on the first edge with hold=0.
REQ-023 DWELL=1 SHALL advance p every cycle.

Reset
REQ-024 rst low SHALL immediately, without clk, force f=0, f_ch=0, f_vld=0, wrap=0, p=0, cnt=0, sampled mode=0, including mid-scan.
REQ-025 First capture SHALL occur on the first rising clk edge after rst deasserts.

Configuration
REQ-026 Macro MUX_SCAN_AUTOSCAN_EN defined: scan mode per REQ-016..REQ-023 SHALL be present.
REQ-027 MUX_SCAN_AUTOSCAN_EN undefined: mode SHALL be ignored (manual always), p/cnt logic SHALL be absent, wrap SHALL be tied 0.

Structure
REQ-028 Package mux_scan_pkg SHALL hold the mode encoding constants (MODE_MANUAL, MODE_SCAN) and the default values of DW, NCH, DWELL.
REQ-029 Sub-module mux_scan_seq SHALL own p, cnt and wrap generation (inputs: clk, rst, en, load, load_val); the top owns the data mux and output registers.

Verification (DW=2, NCH=4, DWELL=3 unless stated; din ch3..ch0 = 11,10,01,00)
REQ-030 Manual, sel=2 -> one edge later f=2'b10, f_ch=2, f_vld=1.
REQ-031 mode 0->1 with sel=1 -> f_ch sequence 1,1,1,2,2,2,3,3,3,0,...; wrap=1 only on the first 0 cycle.
REQ-032 hold=1 for 5 cycles after the 2nd cycle on ch2 -> f, f_ch frozen at 10/2, wrap=0; after release ch2 shows 1 more cycle, then 3.
REQ-033 NCH=5, manual, sel=6 after sel=4 -> f keeps ch4 data, f_vld=0.
REQ-034 rst low mid-scan between clock edges -> f, f_ch, f_vld, wrap read 0 before the next edge.
REQ-035 Build without MUX_SCAN_AUTOSCAN_EN, mode=1, sel=3 -> f=2'b11 every cycle, wrap never 1.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants for the mux_scan block.
//   MODE_MANUAL / MODE_SCAN : encoding of the mode input
//   DW_DEF / NCH_DEF / DWELL_DEF : default parameter values
//   idx_w() : width of an index/counter covering n values (min 1 bit)
package mux_scan_pkg;

    localparam int unsigned DW_DEF    = 2;
    localparam int unsigned NCH_DEF   = 4;
    localparam int unsigned DWELL_DEF = 8;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Bits needed to index n items; never returns 0 so n=1 still gets a wire.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_if.sv
// mux_scan_if: channel-select bus between a driver (master) and mux_scan (slave).
//   mode : 0 manual select, 1 auto-scan
//   sel  : channel index (manual select / scan start point)
//   din  : NCH packed channels of DW bits, channel k at [k*DW +: DW]
//   hold : freeze all state
//   f, f_ch, f_vld, wrap : registered selected data, its channel, valid, scan wrap pulse
interface mux_scan_if
    import mux_scan_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned NCH = NCH_DEF
);
    localparam int unsigned SW = idx_w(NCH);

    logic              mode;
    logic [SW-1:0]     sel;
    logic [NCH*DW-1:0] din;
    logic              hold;
    logic [DW-1:0]     f;
    logic [SW-1:0]     f_ch;
    logic              f_vld;
    logic              wrap;

    modport master (output mode, sel, din, hold, input f, f_ch, f_vld, wrap);
    modport slave  (input mode, sel, din, hold, output f, f_ch, f_vld, wrap);

endinterface

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: scan pointer and dwell counter with wrap pulse generation.
//   clk, rst (async, active-low)
//   en       : advance the dwell/pointer by one cycle
//   load     : restart scan at load_val with a cleared dwell counter
//   load_val : start channel (already range-checked by the caller)
//   p_nxt_c  : pointer value after this edge (combinational); the channel shown next
//   wrap     : registered, high for the cycle after the pointer wraps NCH-1 -> 0
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned DWELL = DWELL_DEF,
    localparam int unsigned SW   = idx_w(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [SW-1:0] load_val,
    output logic [SW-1:0] p_nxt_c,
    output logic          wrap
);
    localparam int unsigned CW = idx_w(DWELL);

    logic [SW-1:0] p;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt_c;
    logic          wrap_nxt_c;

    // Next pointer/counter; a load restarts the dwell on the start channel.
    always_comb begin
        p_nxt_c    = p;
        cnt_nxt_c  = cnt;
        wrap_nxt_c = 1'b0;
        if (load) begin
            p_nxt_c   = load_val;
            cnt_nxt_c = '0;
        end else if (en) begin
            if (cnt == CW'(DWELL - 1)) begin
                cnt_nxt_c = '0;
                if (p == SW'(NCH - 1)) begin
                    p_nxt_c    = '0;
                    wrap_nxt_c = 1'b1;
                end else begin
                    p_nxt_c = p + 1'b1;
                end
            end else begin
                cnt_nxt_c = cnt + 1'b1;
            end
        end
    end

    // State registers; wrap drops to 0 on any cycle without a wrapping step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p    <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            p    <= p_nxt_c;
            cnt  <= cnt_nxt_c;
            wrap <= wrap_nxt_c;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel data selector with optional auto-scan.
//   clk, rst (async, active-low)
//   bus (mux_scan_if.slave): mode, sel, din, hold in; f, f_ch, f_vld, wrap out
// Build option: define MUX_SCAN_AUTOSCAN_EN to include the auto-scan mode.
// Without it mode is ignored, the scan sequencer is not built and wrap is 0.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned DWELL = DWELL_DEF
) (
    input  logic     clk,
    input  logic     rst,
    mux_scan_if.slave bus
);
    localparam int unsigned SW    = idx_w(NCH);
    localparam logic [SW:0] NCH_V = (SW + 1)'(NCH);

    logic [DW-1:0] f_q;
    logic [SW-1:0] f_ch_q;
    logic          f_vld_q;

    logic          sel_ok_c;
    logic [DW-1:0] sel_data_c;
    logic          scan_c;
    logic [SW-1:0] scan_ch_c;
    logic [DW-1:0] scan_data_c;

    // Channel k of a packed din word.
    function automatic logic [DW-1:0] chan_at(input logic [NCH*DW-1:0] d, input logic [SW-1:0] idx);
        chan_at = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (idx == SW'(k)) chan_at = d[k*DW +: DW];
        end
    endfunction

    // sel can exceed NCH-1 when NCH is not a power of two.
    assign sel_ok_c   = ({1'b0, bus.sel} < NCH_V);
    assign sel_data_c = chan_at(bus.din, bus.sel);

`ifdef MUX_SCAN_AUTOSCAN_EN
    logic          mode_q;
    logic          load_c;
    logic          step_c;
    logic [SW-1:0] start_c;
    logic          wrap_q;

    // A sampled 0->1 mode edge restarts the scan; later scan cycles step it.
    assign scan_c  = (bus.mode == MODE_SCAN);
    assign load_c  = !bus.hold && scan_c && (mode_q == MODE_MANUAL);
    assign step_c  = !bus.hold && scan_c && (mode_q == MODE_SCAN);
    assign start_c = sel_ok_c ? bus.sel : '0;

    mux_scan_seq #(
        .NCH   (NCH),
        .DWELL (DWELL)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .en       (step_c),
        .load     (load_c),
        .load_val (start_c),
        .p_nxt_c  (scan_ch_c),
        .wrap     (wrap_q)
    );

    assign scan_data_c = chan_at(bus.din, scan_ch_c);

    // Mode as last seen on an unheld edge, for transition detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           mode_q <= MODE_MANUAL;
        else if (!bus.hold) mode_q <= bus.mode;
    end

    assign bus.wrap = wrap_q;
`else
    logic unused_mode;

    assign unused_mode = bus.mode;
    assign scan_c      = 1'b0;
    assign scan_ch_c   = '0;
    assign scan_data_c = '0;
    assign bus.wrap    = 1'b0;
`endif

    // Output capture; an out-of-range manual sel keeps f/f_ch and clears f_vld.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_q     <= '0;
            f_ch_q  <= '0;
            f_vld_q <= 1'b0;
        end else if (!bus.hold) begin
            if (scan_c) begin
                f_q     <= scan_data_c;
                f_ch_q  <= scan_ch_c;
                f_vld_q <= 1'b1;
            end else if (sel_ok_c) begin
                f_q     <= sel_data_c;
                f_ch_q  <= bus.sel;
                f_vld_q <= 1'b1;
            end else begin
                f_vld_q <= 1'b0;
            end
        end
    end

    assign bus.f     = f_q;
    assign bus.f_ch  = f_ch_q;
    assign bus.f_vld = f_vld_q;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed checks of mux_scan (DW=2, DWELL=3) on an NCH=4 and an NCH=5 instance.
// Table rows drive one instance (the other is held) and compare f/f_ch/f_vld/wrap after the edge.
// Scan sequences are compiled when MUX_SCAN_AUTOSCAN_EN is defined; otherwise mode=1 is checked
// to behave as manual select.
module tb_mux_scan;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_scan_if #(.DW(2), .NCH(4)) b4 ();
    mux_scan_if #(.DW(2), .NCH(5)) b5 ();

    mux_scan #(.DW(2), .NCH(4), .DWELL(3)) u4 (.clk(clk), .rst(rst), .bus(b4));
    mux_scan #(.DW(2), .NCH(5), .DWELL(3)) u5 (.clk(clk), .rst(rst), .bus(b5));

    localparam logic [9:0] D4  = 10'h0E4; // ch3..ch0 = 11,10,01,00
    localparam logic [9:0] D4B = 10'h01B; // ch3..ch0 = 00,01,10,11
    localparam logic [9:0] D5  = 10'h2E4; // ch4..ch0 = 10,11,10,01,00

    typedef struct {
        logic       which;  // 0: NCH=4 instance, 1: NCH=5 instance
        logic       mode;
        logic [2:0] sel;
        logic       hold;
        logic [9:0] din;
        logic [1:0] ef;
        logic [2:0] ech;
        logic       ev;
        logic       ew;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_a[13] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
    int   exp_b[14] = '{2, 2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 0, 0, 0};

    function automatic void add(input logic which, input logic mode, input logic [2:0] sel,
                                input logic hold, input logic [9:0] din, input logic [1:0] ef,
                                input logic [2:0] ech, input logic ev, input logic ew);
        tbl.push_back('{which, mode, sel, hold, din, ef, ech, ev, ew});
    endfunction

    // Drive the selected instance; the other one is held so its state stays put.
    task automatic drive(input logic which, input logic mode, input logic [2:0] sel,
                         input logic hold, input logic [9:0] din);
        if (!which) begin
            b4.mode = mode; b4.sel = sel[1:0]; b4.hold = hold; b4.din = din[7:0];
            b5.hold = 1'b1;
        end else begin
            b5.mode = mode; b5.sel = sel; b5.hold = hold; b5.din = din;
            b4.hold = 1'b1;
        end
    endtask

    task automatic compare(input string nm, input logic which, input logic [6:0] exp_v);
        logic [6:0] got;
        got = which ? {b5.f, b5.f_ch, b5.f_vld, b5.wrap}
                    : {b4.f, 1'b0, b4.f_ch, b4.f_vld, b4.wrap};
        n_vec++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got f=%b f_ch=%0d f_vld=%b wrap=%b, expected f=%b f_ch=%0d f_vld=%b wrap=%b",
                     nm, got[6:5], got[4:2], got[1], got[0],
                     exp_v[6:5], exp_v[4:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic step_chk(input string nm, input logic which, input logic [1:0] ef,
                            input logic [2:0] ech, input logic ev, input logic ew);
        @(posedge clk);
        #1;
        compare(nm, which, {ef, ech, ev, ew});
    endtask

    initial begin
        // Manual select on NCH=4, including hold and din changes
        add(0, 0, 3'd2, 0, D4,  2'b10, 3'd2, 1, 0);
        add(0, 0, 3'd0, 0, D4,  2'b00, 3'd0, 1, 0);
        add(0, 0, 3'd3, 0, D4,  2'b11, 3'd3, 1, 0);
        add(0, 0, 3'd1, 1, D4,  2'b11, 3'd3, 1, 0);
        add(0, 0, 3'd1, 1, D4B, 2'b11, 3'd3, 1, 0);
        add(0, 0, 3'd1, 0, D4B, 2'b10, 3'd1, 1, 0);
        add(0, 0, 3'd3, 0, D4B, 2'b00, 3'd3, 1, 0);
        add(0, 0, 3'd0, 0, D4,  2'b00, 3'd0, 1, 0);
        add(0, 0, 3'd1, 0, D4,  2'b01, 3'd1, 1, 0);
        // NCH=5: out-of-range sel keeps data, drops valid
        add(1, 0, 3'd4, 0, D5,  2'b10, 3'd4, 1, 0);
        add(1, 0, 3'd6, 0, D5,  2'b10, 3'd4, 0, 0);
        add(1, 0, 3'd5, 0, D5,  2'b10, 3'd4, 0, 0);
        add(1, 0, 3'd2, 1, D5,  2'b10, 3'd4, 0, 0);
        add(1, 0, 3'd2, 0, D5,  2'b10, 3'd2, 1, 0);
        add(1, 0, 3'd7, 0, D5,  2'b10, 3'd2, 0, 0);
        add(1, 0, 3'd0, 0, D5,  2'b00, 3'd0, 1, 0);
`ifndef MUX_SCAN_AUTOSCAN_EN
        // Without the scan option mode=1 is plain manual select
        add(0, 1, 3'd3, 0, D4,  2'b11, 3'd3, 1, 0);
        add(0, 1, 3'd3, 0, D4,  2'b11, 3'd3, 1, 0);
        add(0, 1, 3'd3, 0, D4,  2'b11, 3'd3, 1, 0);
        add(0, 1, 3'd3, 0, D4,  2'b11, 3'd3, 1, 0);
        add(0, 1, 3'd0, 0, D4,  2'b00, 3'd0, 1, 0);
`endif

        // Asynchronous reset before any clock edge
        rst = 1'b0;
        b4.mode = 1'b0; b4.sel = 2'd0; b4.hold = 1'b0; b4.din = D4[7:0];
        b5.mode = 1'b0; b5.sel = 3'd0; b5.hold = 1'b0; b5.din = D5;
        #3;
        compare("reset_nch4", 0, 7'd0);
        compare("reset_nch5", 1, 7'd0);
        #9;
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].which, tbl[i].mode, tbl[i].sel, tbl[i].hold, tbl[i].din);
            step_chk($sformatf("vec%0d", i), tbl[i].which, tbl[i].ef, tbl[i].ech, tbl[i].ev, tbl[i].ew);
        end

`ifdef MUX_SCAN_AUTOSCAN_EN
        // Scan from channel 1, three cycles per channel, wrap on first ch0 cycle
        for (int i = 0; i < 13; i++) begin
            drive(0, 1, 3'd1, 0, D4);
            step_chk($sformatf("scanA%0d", i), 0, 2'(exp_a[i]), 3'(exp_a[i]), 1, i == 9);
        end
        // Back to manual on the same edge
        drive(0, 0, 3'd0, 0, D4);
        step_chk("scan_to_manual", 0, 2'b00, 3'd0, 1, 0);
        // Scan from ch2; hold for 5 cycles after its 2nd cycle, mode toggled under hold
        for (int i = 0; i < 14; i++) begin
            drive(0, (i >= 4 && i <= 6) ? 1'b0 : 1'b1, 3'd2, (i >= 2 && i <= 6), D4);
            step_chk($sformatf("scanB%0d", i), 0, 2'(exp_b[i]), 3'(exp_b[i]), 1, i == 11);
        end
        // Out-of-range start channel on NCH=5 begins at channel 0
        drive(1, 1, 3'd6, 0, D5);
        step_chk("scan_start_oor", 1, 2'b00, 3'd0, 1, 0);
        drive(1, 1, 3'd6, 0, D5);
        step_chk("scan_start_oor2", 1, 2'b00, 3'd0, 1, 0);
        drive(0, 1, 3'd2, 0, D4);
        @(posedge clk);
        #1;
`endif

        // Reset between edges forces outputs low at once
        #2;
        rst = 1'b0;
        #1;
        compare("midreset_nch4", 0, 7'd0);
        compare("midreset_nch5", 1, 7'd0);
        #1;
        rst = 1'b1;
        drive(0, 1, 3'd2, 0, D4);
        step_chk("post_reset", 0, 2'b10, 3'd2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
